// File: rtl/branch_predictor.sv
// Fetch-stage BTB + bimodal BHT predictor, trained from execute resolutions.
// Define BP_RAS_EN to add a circular return-address stack for RET entries.
module branch_predictor #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int BHT_ENTRIES = 64,
    parameter int RAS_DEPTH   = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            resolve_valid_i,
    input  logic [XLEN-1:0] resolve_pc_i,
    input  logic            resolve_is_cond_i,
    input  logic            resolve_taken_i,
    input  logic [XLEN-1:0] resolve_target_i,
    input  logic            resolve_pred_taken_i,
    input  logic [XLEN-1:0] resolve_pred_target_i,
`ifdef BP_RAS_EN
    input  logic            resolve_is_call_i,
    input  logic            resolve_is_ret_i,
`endif
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int TAG_W  = XLEN - BTB_IW - 2;

    typedef enum logic [1:0] {
        T_COND = 2'd0,
        T_JUMP = 2'd1,
        T_RET  = 2'd2
    } btb_type_e;

    logic              r_btb_v    [BTB_ENTRIES];
    logic [TAG_W-1:0]  r_btb_tag  [BTB_ENTRIES];
    logic [XLEN-1:0]   r_btb_tgt  [BTB_ENTRIES];
    btb_type_e         r_btb_type [BTB_ENTRIES];
    logic [1:0]        r_bht      [BHT_ENTRIES];

    logic [BTB_IW-1:0] w_f_bidx;
    logic [TAG_W-1:0]  w_f_tag;
    logic [BHT_IW-1:0] w_f_hidx;
    logic              w_hit;
    logic [BTB_IW-1:0] w_r_bidx;
    logic [TAG_W-1:0]  w_r_tag;
    logic [BHT_IW-1:0] w_r_hidx;
    btb_type_e         w_r_type;
    logic [XLEN-1:0]   w_ras_top;

    assign w_f_bidx = fetch_pc_i[BTB_IW+1:2];
    assign w_f_tag  = fetch_pc_i[XLEN-1:BTB_IW+2];
    assign w_f_hidx = fetch_pc_i[BHT_IW+1:2];
    assign w_r_bidx = resolve_pc_i[BTB_IW+1:2];
    assign w_r_tag  = resolve_pc_i[XLEN-1:BTB_IW+2];
    assign w_r_hidx = resolve_pc_i[BHT_IW+1:2];

    assign w_hit = fetch_valid_i & r_btb_v[w_f_bidx]
                 & (r_btb_tag[w_f_bidx] == w_f_tag);

    always_comb begin
        pred_taken_o  = 1'b0;
        pred_target_o = '0;
        if (w_hit) begin
            case (r_btb_type[w_f_bidx])
                T_COND: begin
                    if (r_bht[w_f_hidx][1]) begin
                        pred_taken_o  = 1'b1;
                        pred_target_o = r_btb_tgt[w_f_bidx];
                    end
                end
                T_RET: begin
                    pred_taken_o  = 1'b1;
                    pred_target_o = w_ras_top;
                end
                default: begin
                    pred_taken_o  = 1'b1;
                    pred_target_o = r_btb_tgt[w_f_bidx];
                end
            endcase
        end
    end

    always_comb begin
        mispredict_o  = 1'b0;
        redirect_pc_o = '0;
        if (resolve_valid_i) begin
            mispredict_o = (resolve_taken_i != resolve_pred_taken_i)
                         | (resolve_taken_i
                            & (resolve_target_i != resolve_pred_target_i));
            redirect_pc_o = resolve_taken_i ? resolve_target_i
                                            : resolve_pc_i + XLEN'(4);
        end
    end

    always_comb begin
        w_r_type = resolve_is_cond_i ? T_COND : T_JUMP;
`ifdef BP_RAS_EN
        if (resolve_is_ret_i)
            w_r_type = T_RET;
`endif
    end

    // Valid bits and counters need a reset; tag/target/type are qualified by valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                r_btb_v[i] <= 1'b0;
            for (int i = 0; i < BHT_ENTRIES; i++)
                r_bht[i] <= 2'b01;
        end else if (resolve_valid_i) begin
            if (resolve_taken_i)
                r_btb_v[w_r_bidx] <= 1'b1;
            if (resolve_is_cond_i) begin
                if (resolve_taken_i && r_bht[w_r_hidx] != 2'b11)
                    r_bht[w_r_hidx] <= r_bht[w_r_hidx] + 2'b01;
                else if (!resolve_taken_i && r_bht[w_r_hidx] != 2'b00)
                    r_bht[w_r_hidx] <= r_bht[w_r_hidx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (resolve_valid_i && resolve_taken_i) begin
            r_btb_tag[w_r_bidx]  <= w_r_tag;
            r_btb_tgt[w_r_bidx]  <= resolve_target_i;
            r_btb_type[w_r_bidx] <= w_r_type;
        end
    end

`ifdef BP_RAS_EN
    localparam int RAS_IW = $clog2(RAS_DEPTH);
    localparam int CNT_W  = RAS_IW + 1;

    logic [XLEN-1:0]   r_ras [RAS_DEPTH];
    logic [RAS_IW-1:0] r_ras_ptr;
    logic [CNT_W-1:0]  r_ras_cnt;
    logic              w_push;
    logic              w_pop;
    logic [RAS_IW-1:0] w_ptr_inc;
    logic [RAS_IW-1:0] w_ptr_dec;
    logic [XLEN-1:0]   w_ret_addr;

    assign w_push     = resolve_valid_i & resolve_is_call_i;
    assign w_pop      = resolve_valid_i & resolve_is_ret_i;
    assign w_ptr_inc  = r_ras_ptr + 1'b1;
    assign w_ptr_dec  = r_ras_ptr - 1'b1;
    assign w_ret_addr = resolve_pc_i + XLEN'(4);
    assign w_ras_top  = r_ras[r_ras_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push && w_pop)
            r_ras[r_ras_ptr] <= w_ret_addr;
        else if (w_push)
            r_ras[w_ptr_inc] <= w_ret_addr;
    end

    // The last pop leaves the pointer on the drained entry, so it stays the stale top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_push && !w_pop) begin
            r_ras_ptr <= w_ptr_inc;
            if (r_ras_cnt != CNT_W'(RAS_DEPTH))
                r_ras_cnt <= r_ras_cnt + 1'b1;
        end else if (w_pop && !w_push) begin
            if (r_ras_cnt != '0) begin
                r_ras_cnt <= r_ras_cnt - 1'b1;
                if (r_ras_cnt > CNT_W'(1))
                    r_ras_ptr <= w_ptr_dec;
            end
        end
    end
`else
    assign w_ras_top = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; RAS section runs when BP_RAS_EN is defined.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_pc_i = '0;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        resolve_valid_i = 1'b0;
    logic [31:0] resolve_pc_i = '0;
    logic        resolve_is_cond_i = 1'b0;
    logic        resolve_taken_i = 1'b0;
    logic [31:0] resolve_target_i = '0;
    logic        resolve_pred_taken_i = 1'b0;
    logic [31:0] resolve_pred_target_i = '0;
`ifdef BP_RAS_EN
    logic        resolve_is_call_i = 1'b0;
    logic        resolve_is_ret_i = 1'b0;
`endif
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    branch_predictor dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_pc_i            (fetch_pc_i),
        .pred_taken_o          (pred_taken_o),
        .pred_target_o         (pred_target_o),
        .resolve_valid_i       (resolve_valid_i),
        .resolve_pc_i          (resolve_pc_i),
        .resolve_is_cond_i     (resolve_is_cond_i),
        .resolve_taken_i       (resolve_taken_i),
        .resolve_target_i      (resolve_target_i),
        .resolve_pred_taken_i  (resolve_pred_taken_i),
        .resolve_pred_target_i (resolve_pred_target_i),
`ifdef BP_RAS_EN
        .resolve_is_call_i     (resolve_is_call_i),
        .resolve_is_ret_i      (resolve_is_ret_i),
`endif
        .mispredict_o          (mispredict_o),
        .redirect_pc_o         (redirect_pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc);
        fetch_valid_i = v;
        fetch_pc_i    = pc;
        #1;
    endtask

    task automatic res(input logic [31:0] pc, input logic cond,
                       input logic taken, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
        resolve_valid_i       = 1'b1;
        resolve_pc_i          = pc;
        resolve_is_cond_i     = cond;
        resolve_taken_i       = taken;
        resolve_target_i      = tgt;
        resolve_pred_taken_i  = pt;
        resolve_pred_target_i = ptgt;
        #1;
    endtask

    task automatic res_off();
        resolve_valid_i = 1'b0;
`ifdef BP_RAS_EN
        resolve_is_call_i = 1'b0;
        resolve_is_ret_i  = 1'b0;
`endif
        #1;
    endtask

    // Predict-check helper: fetch pc, compare taken and target.
    task automatic pchk(input string tag, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt);
        fetch(1'b1, pc);
        chk({tag, ".tk"}, {31'd0, pred_taken_o}, {31'd0, tk});
        chk({tag, ".tgt"}, pred_target_o, tgt);
    endtask

    initial begin
        step();
        fetch(1'b1, 32'h100);
        chk("rst.tk", {31'd0, pred_taken_o}, 32'd0);
        chk("rst.mp", {31'd0, mispredict_o}, 32'd0);
        rst_ni = 1'b1;
        step();

        pchk("cold", 32'h100, 1'b0, 32'h0);
        chk("cold.mp", {31'd0, mispredict_o}, 32'd0);
        chk("cold.rd", redirect_pc_o, 32'h0);

        res(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("t1.mp", {31'd0, mispredict_o}, 32'd1);
        chk("t1.rd", redirect_pc_o, 32'h80);
        step();
        res_off();
        pchk("t1.pred", 32'h100, 1'b1, 32'h80);
        pchk("lowbits", 32'h102, 1'b1, 32'h80);
        fetch(1'b0, 32'h100);
        chk("novalid.tk", {31'd0, pred_taken_o}, 32'd0);

        res(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("hit.mp", {31'd0, mispredict_o}, 32'd0);
        step();
        step();
        res_off();

        res(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
        chk("nt.mp", {31'd0, mispredict_o}, 32'd1);
        chk("nt.rd", redirect_pc_o, 32'h104);
        step();
        res_off();
        pchk("sat11", 32'h100, 1'b1, 32'h80);
        res(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
        step();
        res_off();
        pchk("ctr01", 32'h100, 1'b0, 32'h0);
        res(32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
        step();
        step();
        res_off();
        res(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        step();
        res_off();
        pchk("sat00", 32'h100, 1'b0, 32'h0);
        res(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        step();
        res_off();
        pchk("ctr10", 32'h100, 1'b1, 32'h80);

        res(32'h304, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        chk("jal.rd", redirect_pc_o, 32'h500);
        step();
        res_off();
        pchk("jal", 32'h304, 1'b1, 32'h500);
        res(32'h304, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ntkeep.mp", {31'd0, mispredict_o}, 32'd0);
        chk("ntkeep.rd", redirect_pc_o, 32'h308);
        step();
        res_off();
        pchk("ntkeep", 32'h304, 1'b1, 32'h500);

        res(32'h140, 1'b1, 1'b1, 32'h90, 1'b0, 32'h0);
        step();
        res_off();
        pchk("alias.old", 32'h100, 1'b0, 32'h0);
        pchk("alias.new", 32'h140, 1'b1, 32'h90);

        fetch(1'b1, 32'h200);
        res(32'h200, 1'b1, 1'b1, 32'h250, 1'b0, 32'h0);
        chk("rbw.tk", {31'd0, pred_taken_o}, 32'd0);
        chk("rbw.mp", {31'd0, mispredict_o}, 32'd1);
        chk("rbw.rd", redirect_pc_o, 32'h250);
        step();
        res_off();
        pchk("rbw.next", 32'h200, 1'b1, 32'h250);

        res(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap.mp", {31'd0, mispredict_o}, 32'd0);
        chk("wrap.rd", redirect_pc_o, 32'h0);
        res(32'h400, 1'b0, 1'b1, 32'h800, 1'b1, 32'h900);
        chk("tgt.mp", {31'd0, mispredict_o}, 32'd1);
        chk("tgt.rd", redirect_pc_o, 32'h800);
        res_off();
        chk("idle.rd", redirect_pc_o, 32'h0);
        step();

`ifdef BP_RAS_EN
        begin
            logic [31:0] exp_ret [5];
            exp_ret[0] = 32'h54;
            exp_ret[1] = 32'h44;
            exp_ret[2] = 32'h34;
            exp_ret[3] = 32'h24;
            exp_ret[4] = 32'h24;
            resolve_is_ret_i = 1'b1;
            res(32'h708, 1'b0, 1'b1, 32'h1234, 1'b0, 32'h0);
            step();
            res_off();
            for (int i = 1; i <= 5; i++) begin
                resolve_is_call_i = 1'b1;
                res(32'h10 * i, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
                step();
            end
            res_off();
            for (int i = 0; i < 5; i++) begin
                pchk($sformatf("ret%0d", i), 32'h708, 1'b1, exp_ret[i]);
                resolve_is_ret_i = 1'b1;
                res(32'h708, 1'b0, 1'b1, exp_ret[i], 1'b1, exp_ret[i]);
                step();
                res_off();
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
